// File: rtl/closest_hit_collector.sv
// closest_hit_collector
//   Folds the per-triangle intersection results of one ray into a single
//   nearest-hit record for the reflection/refraction stage.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          input word handshake (in_ready is registered)
//   in_word                    {code[1:0], t[WIDTH-1:0]}; 2'b10 hit, 2'b00 miss
//   in_tri_idx, in_ray_id      triangle index and ray tag of the word
//   in_last                    word is the last triangle of the ray
//   out_valid/out_ready        result record handshake
//   out_hit, out_t,            nearest hit (t and index are 0 when no hit)
//   out_tri_idx
//   out_ray_id                 tag from the first word of the ray
//   out_count                  words consumed, saturating at all-ones
//   err_flag, err_clear        sticky error (bad code / ray tag change), clear
module closest_hit_collector #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned IDX_W    = 10,
  parameter int unsigned RAY_ID_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH+1:0]    in_word,
  input  logic [IDX_W-1:0]    in_tri_idx,
  input  logic [RAY_ID_W-1:0] in_ray_id,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_hit,
  output logic [WIDTH-1:0]    out_t,
  output logic [IDX_W-1:0]    out_tri_idx,
  output logic [RAY_ID_W-1:0] out_ray_id,
  output logic [IDX_W:0]      out_count,
  output logic                err_flag,
  input  logic                err_clear
);

  typedef enum logic [0:0] {StCollect, StHold} state_e;

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                first_q, first_d;
  logic                best_valid_q, best_valid_d;
  logic [WIDTH-1:0]    best_t_q, best_t_d;
  logic [IDX_W-1:0]    best_idx_q, best_idx_d;
  logic [RAY_ID_W-1:0] ray_id_q, ray_id_d;
  logic [IDX_W:0]      count_q, count_d;
  logic                err_q, err_d;

  logic                out_valid_q, out_valid_d;
  logic                out_hit_q, out_hit_d;
  logic [WIDTH-1:0]    out_t_q, out_t_d;
  logic [IDX_W-1:0]    out_tri_idx_q, out_tri_idx_d;
  logic [RAY_ID_W-1:0] out_ray_id_q, out_ray_id_d;
  logic [IDX_W:0]      out_count_q, out_count_d;

  logic             accept;
  logic [1:0]       code;
  logic [WIDTH-1:0] word_t;
  logic             is_hit;
  logic             closer;
  logic             err_set;
  logic             handshake;

  assign accept    = in_valid && in_ready_q;
  assign code      = in_word[WIDTH+1:WIDTH];
  assign word_t    = in_word[WIDTH-1:0];
  assign is_hit    = (code == 2'b10);
  // Strict less-than: on a tie the earlier triangle keeps the slot.
  assign closer    = !best_valid_q || ($signed(word_t) < $signed(best_t_q));
  assign handshake = out_valid_q && out_ready;
  // Codes 01/11 are malformed; a tag change is only an error after the first word.
  assign err_set   = accept && (code[0] || (!first_q && (in_ray_id != ray_id_q)));

  always_comb begin
    state_d       = state_q;
    first_d       = first_q;
    best_valid_d  = best_valid_q;
    best_t_d      = best_t_q;
    best_idx_d    = best_idx_q;
    ray_id_d      = ray_id_q;
    count_d       = count_q;
    out_valid_d   = out_valid_q;
    out_hit_d     = out_hit_q;
    out_t_d       = out_t_q;
    out_tri_idx_d = out_tri_idx_q;
    out_ray_id_d  = out_ray_id_q;
    out_count_d   = out_count_q;

    unique case (state_q)
      StCollect: begin
        if (accept) begin
          if (!(&count_q)) begin
            count_d = count_q + 1'b1;
          end
          if (first_q) begin
            ray_id_d = in_ray_id;
            first_d  = 1'b0;
          end
          if (is_hit && closer) begin
            best_valid_d = 1'b1;
            best_t_d     = word_t;
            best_idx_d   = in_tri_idx;
          end
          // The last word's own contribution is folded into the record here.
          if (in_last) begin
            state_d       = StHold;
            out_valid_d   = 1'b1;
            out_hit_d     = best_valid_d;
            out_t_d       = best_valid_d ? best_t_d : '0;
            out_tri_idx_d = best_valid_d ? best_idx_d : '0;
            out_ray_id_d  = ray_id_d;
            out_count_d   = count_d;
          end
        end
      end
      StHold: begin
        if (handshake) begin
          state_d       = StCollect;
          out_valid_d   = 1'b0;
          out_hit_d     = 1'b0;
          out_t_d       = '0;
          out_tri_idx_d = '0;
          out_ray_id_d  = '0;
          out_count_d   = '0;
          first_d       = 1'b1;
          best_valid_d  = 1'b0;
          count_d       = '0;
        end
      end
      default: state_d = StCollect;
    endcase

    in_ready_d = (state_d == StCollect);

    // Set wins over a simultaneous clear.
    err_d = err_q;
    if (err_clear) err_d = 1'b0;
    if (err_set)   err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StCollect;
      in_ready_q    <= 1'b0;
      first_q       <= 1'b1;
      best_valid_q  <= 1'b0;
      best_t_q      <= '0;
      best_idx_q    <= '0;
      ray_id_q      <= '0;
      count_q       <= '0;
      err_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_hit_q     <= 1'b0;
      out_t_q       <= '0;
      out_tri_idx_q <= '0;
      out_ray_id_q  <= '0;
      out_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      first_q       <= first_d;
      best_valid_q  <= best_valid_d;
      best_t_q      <= best_t_d;
      best_idx_q    <= best_idx_d;
      ray_id_q      <= ray_id_d;
      count_q       <= count_d;
      err_q         <= err_d;
      out_valid_q   <= out_valid_d;
      out_hit_q     <= out_hit_d;
      out_t_q       <= out_t_d;
      out_tri_idx_q <= out_tri_idx_d;
      out_ray_id_q  <= out_ray_id_d;
      out_count_q   <= out_count_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_hit     = out_hit_q;
  assign out_t       = out_t_q;
  assign out_tri_idx = out_tri_idx_q;
  assign out_ray_id  = out_ray_id_q;
  assign out_count   = out_count_q;
  assign err_flag    = err_q;

endmodule

// File: tb/tb_closest_hit_collector.sv
module tb_closest_hit_collector;
  localparam int unsigned WIDTH    = 32;
  localparam int unsigned IDX_W    = 10;
  localparam int unsigned RAY_ID_W = 8;
  localparam int          MAXC     = (1 << (IDX_W + 1)) - 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [WIDTH+1:0]    in_word = '0;
  logic [IDX_W-1:0]    in_tri_idx = '0;
  logic [RAY_ID_W-1:0] in_ray_id = '0;
  logic                in_last = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic                out_hit;
  logic [WIDTH-1:0]    out_t;
  logic [IDX_W-1:0]    out_tri_idx;
  logic [RAY_ID_W-1:0] out_ray_id;
  logic [IDX_W:0]      out_count;
  logic                err_flag;
  logic                err_clear = 1'b0;

  closest_hit_collector #(
    .WIDTH    (WIDTH),
    .IDX_W    (IDX_W),
    .RAY_ID_W (RAY_ID_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_word     (in_word),
    .in_tri_idx  (in_tri_idx),
    .in_ray_id   (in_ray_id),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_hit     (out_hit),
    .out_t       (out_t),
    .out_tri_idx (out_tri_idx),
    .out_ray_id  (out_ray_id),
    .out_count   (out_count),
    .err_flag    (err_flag),
    .err_clear   (err_clear)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Words of the ray currently being built, plus the sticky error model.
  logic [1:0]          q_code[$];
  logic [WIDTH-1:0]    q_t[$];
  logic [IDX_W-1:0]    q_idx[$];
  logic [RAY_ID_W-1:0] q_id[$];
  logic                exp_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [1:0] c, input logic [WIDTH-1:0] t,
                     input logic [IDX_W-1:0] i, input logic [RAY_ID_W-1:0] id);
    q_code.push_back(c);
    q_t.push_back(t);
    q_idx.push_back(i);
    q_id.push_back(id);
  endtask

  // Called at a negedge; returns at the negedge after the word is accepted.
  task automatic send_word(input logic [1:0] c, input logic [WIDTH-1:0] t,
                           input logic [IDX_W-1:0] i, input logic [RAY_ID_W-1:0] id,
                           input logic last);
    int n;
    in_valid   = 1'b1;
    in_word    = {c, t};
    in_tri_idx = i;
    in_ray_id  = id;
    in_last    = last;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_wait", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Sends the queued ray, checks the record against the model, stalls
  // out_ready for `hold` cycles, then completes the handshake.
  task automatic play_ray(input int hold);
    logic             hit;
    logic [WIDTH-1:0] bt;
    logic [IDX_W-1:0] bi;
    int               n;
    int               cnt;
    hit = 1'b0;
    bt  = '0;
    bi  = '0;
    n   = q_code.size();
    for (int k = 0; k < n; k++) begin
      if (q_code[k][0] || (q_id[k] != q_id[0])) exp_err = 1'b1;
      if (q_code[k] == 2'b10 && (!hit || $signed(q_t[k]) < $signed(bt))) begin
        hit = 1'b1;
        bt  = q_t[k];
        bi  = q_idx[k];
      end
    end
    cnt = (n > MAXC) ? MAXC : n;
    for (int k = 0; k < n; k++) send_word(q_code[k], q_t[k], q_idx[k], q_id[k], k == n - 1);
    check("out_valid_lat", {63'd0, out_valid}, 64'd1);
    check("in_ready_low", {63'd0, in_ready}, 64'd0);
    check("out_hit", {63'd0, out_hit}, {63'd0, hit});
    check("out_t", {32'd0, out_t}, {32'd0, bt});
    check("out_tri_idx", {54'd0, out_tri_idx}, {54'd0, bi});
    check("out_ray_id", {56'd0, out_ray_id}, {56'd0, q_id[0]});
    check("out_count", {53'd0, out_count}, 64'(cnt));
    check("err_flag", {63'd0, err_flag}, {63'd0, exp_err});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      check("hold_t", {32'd0, out_t}, {32'd0, bt});
      check("hold_idx", {54'd0, out_tri_idx}, {54'd0, bi});
      check("hold_count", {53'd0, out_count}, 64'(cnt));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_fall", {63'd0, out_valid}, 64'd0);
    check("in_ready_rise", {63'd0, in_ready}, 64'd1);
    q_code.delete();
    q_t.delete();
    q_idx.delete();
    q_id.delete();
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    err_clear = 1'b0;
    exp_err   = 1'b0;
    check("err_cleared", {63'd0, err_flag}, 64'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] tv;
    int               len;
    logic [RAY_ID_W-1:0] rid;

    // Reset state
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_err", {63'd0, err_flag}, 64'd0);
    check("rst_count", {53'd0, out_count}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_pre_edge", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    check("in_ready_post_rst", {63'd0, in_ready}, 64'd1);

    // 1: nearest of two hits
    add(2'b00, 32'h0, 10'd0, 8'd5);
    add(2'b10, 32'h0001_8000, 10'd1, 8'd5);
    add(2'b10, 32'h0000_8000, 10'd2, 8'd5);
    play_ray(0);

    // 2: all misses
    for (int k = 0; k < 4; k++) add(2'b00, 32'h1234 + k, 10'(k + 4), 8'd9);
    play_ray(0);

    // 3: tie keeps the earlier triangle
    add(2'b10, 32'h0001_0000, 10'd3, 8'd1);
    add(2'b10, 32'h0001_0000, 10'd7, 8'd1);
    play_ray(0);

    // 4: downstream stall
    add(2'b10, 32'h0004_0000, 10'd11, 8'd2);
    add(2'b10, 32'hFFFF_0000, 10'd12, 8'd2);
    add(2'b00, 32'h0, 10'd13, 8'd2);
    play_ray(5);

    // 5: malformed code counts as miss and flags an error
    add(2'b11, 32'h0000_0100, 10'd0, 8'd4);
    add(2'b10, 32'h0002_0000, 10'd1, 8'd4);
    play_ray(0);
    pulse_clear();

    // Tag change within a ray; error survives the next ray
    add(2'b10, 32'h5, 10'd0, 8'd3);
    add(2'b00, 32'h0, 10'd1, 8'd4);
    play_ray(0);
    add(2'b10, 32'h9, 10'd2, 8'd6);
    play_ray(1);
    pulse_clear();

    // Set wins over a simultaneous clear
    err_clear = 1'b1;
    send_word(2'b10, 32'h7, 10'd1, 8'd8, 1'b0);
    send_word(2'b01, 32'h3, 10'd2, 8'd8, 1'b1);
    err_clear = 1'b0;
    check("set_over_clear", {63'd0, err_flag}, 64'd1);
    check("soc_t", {32'd0, out_t}, 64'h7);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    pulse_clear();

    // Count saturation
    for (int k = 0; k < MAXC + 3; k++) add(2'b00, 32'h0, 10'(k), 8'd10);
    play_ray(0);

    // Randomized rays against the model
    for (int r = 0; r < 25; r++) begin
      len = $urandom_range(1, 6);
      rid = 8'($urandom);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) tv = $urandom;
        else tv = ($urandom_range(0, 7) << 16) - 32'h0004_0000;
        add(($urandom_range(0, 2) != 0) ? 2'b10 : 2'b00, tv, 10'($urandom_range(0, 1023)), rid);
      end
      play_ray($urandom_range(0, 3));
    end

    // 6: reset mid-ray discards the partial accumulation
    send_word(2'b10, 32'h0000_1000, 10'd1, 8'd7, 1'b0);
    send_word(2'b11, 32'h0000_0800, 10'd2, 8'd7, 1'b0);
    check("pre_rst_err", {63'd0, err_flag}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("mid_rst_err", {63'd0, err_flag}, 64'd0);
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    exp_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    add(2'b10, 32'h0003_0000, 10'd9, 8'd8);
    play_ray(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
